// File: rtl/calc_cmd_arbiter.sv
// Two-requester command arbiter in front of a calculator: round-robin grant with
// per-transaction locking. Optional watchdog enabled by defining CALC_ARB_TIMEOUT_EN.
module calc_cmd_arbiter #(
  parameter logic [3:0] IDLE_CMD       = 4'hD,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_cmd,
  input  logic       req1_valid,
  input  logic [3:0] req1_cmd,
  input  logic [1:0] calc_status,
  output logic [3:0] calc_cmd,
  output logic       req0_ack,
  output logic       req1_ack,
  output logic       owner,
  output logic       locked,
  output logic       err,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, ERROR} state_t;

  localparam logic [1:0] STATUS_ERR   = 2'b00;
  localparam logic [1:0] STATUS_READY = 2'b10;
  localparam logic [3:0] CMD_EQUALS   = 4'hE;

  state_t     state_reg;
  logic [3:0] calc_cmd_reg;
  logic       req0_ack_reg;
  logic       req1_ack_reg;
  logic       owner_reg;
  logic       locked_reg;
  logic       err_reg;

  logic       grant_valid;
  logic       grant_idx;
  logic [3:0] grant_cmd;
  logic       wd_expire;

  // A locked transaction keeps the bus for its owner until it sends "equals".
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = owner_reg;
    if (locked_reg) begin
      grant_valid = owner_reg ? req1_valid : req0_valid;
      grant_idx   = owner_reg;
    end else if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_idx   = ~owner_reg;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end
  end

  assign grant_cmd = grant_idx ? req1_cmd : req0_cmd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      calc_cmd_reg <= IDLE_CMD;
      req0_ack_reg <= 1'b0;
      req1_ack_reg <= 1'b0;
      owner_reg    <= 1'b1;
      locked_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      req0_ack_reg <= 1'b0;
      req1_ack_reg <= 1'b0;
      if (state_reg != ERROR && (calc_status == STATUS_ERR || wd_expire)) begin
        state_reg    <= ERROR;
        err_reg      <= 1'b1;
        calc_cmd_reg <= IDLE_CMD;
      end else begin
        case (state_reg)
          IDLE: begin
            if (calc_status == STATUS_READY && grant_valid) begin
              owner_reg    <= grant_idx;
              calc_cmd_reg <= grant_cmd;
              state_reg    <= DRIVE;
            end
          end
          DRIVE: begin
            // Calculator leaving "ready" means it has consumed the command.
            if (calc_status != STATUS_READY) begin
              if (owner_reg) req1_ack_reg <= 1'b1;
              else           req0_ack_reg <= 1'b1;
              locked_reg   <= (calc_cmd_reg != CMD_EQUALS);
              calc_cmd_reg <= IDLE_CMD;
              state_reg    <= SETTLE;
            end
          end
          SETTLE: begin
            if (calc_status == STATUS_READY) state_reg <= IDLE;
          end
          ERROR: begin
            calc_cmd_reg <= IDLE_CMD;
          end
          default: begin
            state_reg    <= IDLE;
            calc_cmd_reg <= IDLE_CMD;
          end
        endcase
      end
    end
  end

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;
  logic            wd_waiting;

  // True only on cycles where the FSM will stay in DRIVE or SETTLE.
  assign wd_waiting = (state_reg == DRIVE  && calc_status == STATUS_READY) ||
                      (state_reg == SETTLE && calc_status[0]);
  assign wd_expire  = wd_waiting && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (wd_expire) timeout_reg <= 1'b1;
      if (wd_expire || !wd_waiting) wd_cnt_reg <= '0;
      else                          wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign calc_cmd = calc_cmd_reg;
  assign req0_ack = req0_ack_reg;
  assign req1_ack = req1_ack_reg;
  assign owner    = owner_reg;
  assign locked   = locked_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Directed bench for calc_cmd_arbiter (default build, watchdog disabled).
module tb_calc_cmd_arbiter;

  logic       clock;
  logic       reset;
  logic       req0_valid;
  logic [3:0] req0_cmd;
  logic       req1_valid;
  logic [3:0] req1_cmd;
  logic [1:0] calc_status;
  logic [3:0] calc_cmd;
  logic       req0_ack;
  logic       req1_ack;
  logic       owner;
  logic       locked;
  logic       err;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  calc_cmd_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_cmd    (req0_cmd),
    .req1_valid  (req1_valid),
    .req1_cmd    (req1_cmd),
    .calc_status (calc_status),
    .calc_cmd    (calc_cmd),
    .req0_ack    (req0_ack),
    .req1_ack    (req1_ack),
    .owner       (owner),
    .locked      (locked),
    .err         (err),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  logic [3:0] seq [4];

  initial begin
    seq = '{4'h1, 4'hA, 4'h2, 4'hE};
    reset = 1'b1;
    req0_valid = 1'b0; req0_cmd = 4'h0;
    req1_valid = 1'b0; req1_cmd = 4'h0;
    calc_status = 2'b10;
    tick(); tick();

    // Reset state
    chk("rst_cmd", 8'(calc_cmd), 8'hD);
    chk("rst_ack0", 8'(req0_ack), 8'h0);
    chk("rst_ack1", 8'(req1_ack), 8'h0);
    chk("rst_owner", 8'(owner), 8'h1);
    chk("rst_locked", 8'(locked), 8'h0);
    chk("rst_err", 8'(err), 8'h0);
    chk("rst_timeout", 8'(timeout), 8'h0);

    // Both valid at reset exit: requester 0 wins, then locks requester 1 out
    req0_valid = 1'b1; req0_cmd = 4'h3;
    req1_valid = 1'b1; req1_cmd = 4'h5;
    reset = 1'b0;
    tick();
    $display("txn: first simultaneous grant calc_cmd=%0h owner=%0d", calc_cmd, owner);
    chk("b_grant_cmd", 8'(calc_cmd), 8'h3);
    chk("b_grant_owner", 8'(owner), 8'h0);
    calc_status = 2'b01; req0_valid = 1'b0;
    tick();
    chk("b_ack0", 8'(req0_ack), 8'h1);
    chk("b_ack1_quiet", 8'(req1_ack), 8'h0);
    chk("b_cmd_idle", 8'(calc_cmd), 8'hD);
    chk("b_locked", 8'(locked), 8'h1);
    calc_status = 2'b10;
    tick();
    chk("b_ack0_pulse", 8'(req0_ack), 8'h0);
    tick(); tick();
    chk("b_blocked_cmd", 8'(calc_cmd), 8'hD);
    chk("b_blocked_owner", 8'(owner), 8'h0);
    req0_valid = 1'b1; req0_cmd = 4'hE;
    tick();
    chk("b_eq_cmd", 8'(calc_cmd), 8'hE);
    req0_cmd = 4'h4; req0_valid = 1'b0; calc_status = 2'b01;
    tick();
    $display("txn: req0 equals acked ack0=%0d locked=%0d", req0_ack, locked);
    chk("b_eq_ack0", 8'(req0_ack), 8'h1);
    chk("b_unlocked", 8'(locked), 8'h0);
    calc_status = 2'b10;
    tick();
    chk("b_settle_no_grant", 8'(calc_cmd), 8'hD);
    tick();
    chk("b_req1_cmd", 8'(calc_cmd), 8'h5);
    chk("b_req1_owner", 8'(owner), 8'h1);
    calc_status = 2'b01;
    tick();
    chk("b_ack1", 8'(req1_ack), 8'h1);
    chk("b_ack0_quiet", 8'(req0_ack), 8'h0);
    calc_status = 2'b10; req1_valid = 1'b0;
    tick();

    // Unlock requester 1 with an equals
    req1_valid = 1'b1; req1_cmd = 4'hE;
    tick();
    calc_status = 2'b01; req1_valid = 1'b0;
    tick();
    chk("c_unlock", 8'(locked), 8'h0);
    calc_status = 2'b10;
    tick();

    // Sequence 1,A,2,E from req0 while req1 waits with 9
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_cmd = seq[i];
      req1_valid = 1'b1; req1_cmd = 4'h9;
      tick();
      $display("txn: seq[%0d] calc_cmd=%0h owner=%0d", i, calc_cmd, owner);
      chk("c_seq_cmd", 8'(calc_cmd), 8'(seq[i]));
      chk("c_seq_owner", 8'(owner), 8'h0);
      calc_status = 2'b01;
      if (i == 3) req0_valid = 1'b0;
      tick();
      chk("c_seq_ack0", 8'(req0_ack), 8'h1);
      chk("c_seq_ack1", 8'(req1_ack), 8'h0);
      chk("c_seq_locked", 8'(locked), (seq[i] == 4'hE) ? 8'h0 : 8'h1);
      calc_status = 2'b10;
      tick();
    end
    tick();
    chk("c_req1_cmd", 8'(calc_cmd), 8'h9);
    chk("c_req1_owner", 8'(owner), 8'h1);
    calc_status = 2'b01;
    tick();
    chk("c_req1_ack", 8'(req1_ack), 8'h1);
    calc_status = 2'b10; req1_valid = 1'b0;
    tick();

    // Reset while driving C
    req1_valid = 1'b1; req1_cmd = 4'hC;
    tick();
    chk("d_drive_cmd", 8'(calc_cmd), 8'hC);
    reset = 1'b1;
    #1;
    $display("txn: async reset mid-DRIVE calc_cmd=%0h locked=%0d", calc_cmd, locked);
    chk("d_rst_cmd", 8'(calc_cmd), 8'hD);
    chk("d_rst_ack1", 8'(req1_ack), 8'h0);
    chk("d_rst_locked", 8'(locked), 8'h0);
    chk("d_rst_owner", 8'(owner), 8'h1);
    req1_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Error during SETTLE is sticky until reset
    req0_valid = 1'b1; req0_cmd = 4'h8;
    tick();
    chk("e_grant_cmd", 8'(calc_cmd), 8'h8);
    calc_status = 2'b01; req0_valid = 1'b0;
    tick();
    chk("e_ack0", 8'(req0_ack), 8'h1);
    calc_status = 2'b00;
    tick();
    $display("txn: status error in SETTLE err=%0d", err);
    chk("e_err", 8'(err), 8'h1);
    chk("e_err_cmd", 8'(calc_cmd), 8'hD);
    calc_status = 2'b10;
    req0_valid = 1'b1; req0_cmd = 4'h2;
    req1_valid = 1'b1; req1_cmd = 4'h3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("e_hold_ack0", 8'(req0_ack), 8'h0);
      chk("e_hold_ack1", 8'(req1_ack), 8'h0);
      chk("e_hold_err", 8'(err), 8'h1);
      chk("e_hold_cmd", 8'(calc_cmd), 8'hD);
    end
    chk("e_timeout", 8'(timeout), 8'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("e_rst_err", 8'(err), 8'h0);
    tick();
    reset = 1'b0;

    // Lone requester 1 granted although owner is 1; error in DRIVE gives no ack
    req1_valid = 1'b1; req1_cmd = 4'h6;
    tick();
    $display("txn: lone req1 grant calc_cmd=%0h owner=%0d", calc_cmd, owner);
    chk("f_grant_cmd", 8'(calc_cmd), 8'h6);
    chk("f_grant_owner", 8'(owner), 8'h1);
    calc_status = 2'b00; req1_valid = 1'b0;
    tick();
    chk("f_err", 8'(err), 8'h1);
    chk("f_no_ack1", 8'(req1_ack), 8'h0);
    chk("f_locked", 8'(locked), 8'h0);
    chk("f_cmd", 8'(calc_cmd), 8'hD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
